mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle iterative multiply/divide unit for the CPU datapath; the sequential counterpart to the single-cycle ALU.
- Executes MIPS MULT/MULTU/DIV/DIVU into internal HI/LO registers, and services MTHI/MTLO writes.
- Handshake with the pipeline: start pulse in, busy/done out. The control unit stalls on MFHI/MFLO while busy is high.

Parameters:
- ITER, 32, iterations per operation (radix-2, one bit per cycle). Must equal the operand width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  launch operation; sampled only when not busy
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- opr1  input  32  multiplicand / dividend (rs)
- opr2  input  32  multiplier / divisor (rt)
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  32  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter=0.
  - Reset during CALC aborts the operation and discards partial results.
- States: IDLE, CALC, DONE. busy=1 only in CALC; done=1 only in DONE; hi/lo are registered outputs.
- IDLE or DONE, start=1 at edge E:
  - Latch op and operand magnitudes plus result-sign flags; counter=0; go to CALC.
  - hi_we/lo_we in that same cycle are still honoured.
- CALC:
  - One iteration per edge, counter increments.
  - At the edge where counter==ITER-1, perform the final iteration, sign-fix, write hi/lo, and go to DONE.
- Latency: start sampled at edge E gives hi/lo valid and done=1 after edge E+32, during the cycle E+32..E+33.
- DONE -> IDLE at the next edge unless start=1, in which case DONE -> CALC (back-to-back operations allowed).
- start, hi_we, lo_we while busy=1 are ignored; no queuing.
- hi_we/lo_we in IDLE/DONE: at the edge, hi<=wdata and/or lo<=wdata. Both strobes may be asserted together.
- MULT/MULTU: {hi,lo} = full 64-bit product, signed or unsigned respectively.
  - Signed path: multiply magnitudes unsigned, then negate the 64-bit result if the operand signs differ.
- DIV/DIVU: restoring division on magnitudes; lo=quotient, hi=remainder.
  - Signed quotient is truncated toward zero; remainder takes the sign of the dividend.
- Divide by zero (opr2==0, DIV or DIVU):
  - No exception; normal latency.
  - hi=opr1 unchanged, lo=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000; no overflow flag.
- Operands are latched at start; later changes on opr1/opr2/op during CALC have no effect.
- hi/lo hold their previous values throughout CALC; they change only at completion or on a strobe write.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 cycles after start (after edge E+32); hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles.
- MULT 0xFFFFFFFD(-3)*0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/0 -> hi=0x00000064, lo=0xFFFFFFFF, same latency. DIV 0xFFFFFF9C/0 -> hi=0xFFFFFF9C, lo=0xFFFFFFFF.
- During CALC, pulse start with new operands and hi_we=1/wdata=0x1234 -> both ignored; original result lands. In DONE, start=1 -> next op begins with no IDLE cycle.
- reset=1 at iteration 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0, state IDLE. A fresh start then completes normally; lo_we in IDLE writes lo at the next edge.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// MULT/MULTU use shift-add on operand magnitudes; DIV/DIVU use restoring
// division on magnitudes. Signs are fixed up on the final iteration.
module mult_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opr1,
    input  logic [31:0] opr2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    logic          neg_lo_q, neg_lo_d;   // negate product / quotient
    logic          neg_hi_q, neg_hi_d;   // negate remainder
    logic [63:0]   acc_q, acc_d;         // product, or {remainder, quotient}
    logic [31:0]   opb_q, opb_d;         // multiplicand or divisor magnitude
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          sgn1, sgn2;
    logic [31:0]   mag1, mag2;
    logic [32:0]   mul_sum;
    logic [63:0]   mul_next;
    logic [32:0]   div_shift;
    logic [31:0]   div_diff;
    logic          div_ge;
    logic [63:0]   div_next;
    logic [63:0]   step;
    logic [63:0]   mul_res;

    // Operand magnitudes and one iteration of the shared datapath
    always_comb begin
        sgn1      = ~op[0] & opr1[31];
        sgn2      = ~op[0] & opr2[31];
        mag1      = sgn1 ? -opr1 : opr1;
        mag2      = sgn2 ? -opr2 : opr2;

        // Shift-add: add multiplicand into the upper half when the LSB is set, then shift right
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};

        // Restoring step: shift next dividend bit into remainder, subtract if it fits.
        // The remainder never exceeds the divisor, so the 32-bit difference is exact.
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_diff  = div_shift[31:0] - opb_q;
        div_next  = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                           : {div_shift[31:0], acc_q[30:0], 1'b0};

        step      = is_div_q ? div_next : mul_next;
        mul_res   = neg_lo_q ? -step : step;
    end

    // Next-state, datapath and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    // Divide by zero must leave the all-ones quotient unsigned
                    neg_lo_d = op[1] ? ((sgn1 ^ sgn2) & (opr2 != 32'd0)) : (sgn1 ^ sgn2);
                    neg_hi_d = sgn1;
                    acc_d    = {32'd0, op[1] ? mag1 : mag2};
                    opb_d    = op[1] ? mag2 : mag1;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (is_div_q) begin
                        lo_d = neg_lo_q ? -step[31:0]  : step[31:0];
                        hi_d = neg_hi_q ? -step[63:32] : step[63:32];
                    end else begin
                        hi_d = mul_res[63:32];
                        lo_d = mul_res[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes expected HI/LO and
// completion cycle per operation; a monitor pops and compares on each done.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opr1 = '0;
    logic [31:0] opr2 = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [63:0] sb_q[$];
    int          lat_q[$];

    mult_div_unit #(.ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .opr1(opr1), .opr2(opr2), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare every completion against the scoreboard head
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                logic [63:0] e;
                int          ec;
                e  = sb_q.pop_front();
                ec = lat_q.pop_front();
                chk("result_hi", hi, e[63:32]);
                chk("result_lo", lo, e[31:0]);
                chk("latency_cycle", cyc, ec);
                $display("done: hi=%h lo=%h cycle=%0d", hi, lo, cyc);
            end
        end
    end

    // Call at a negedge with the unit in IDLE or DONE
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit push);
        op = o; opr1 = a; opr2 = b; start = 1'b1;
        if (push) begin
            sb_q.push_back({eh, el});
            lat_q.push_back(cyc + 33);
        end
        $display("issue: op=%0d opr1=%h opr2=%h expect hi=%h lo=%h", o, a, b, eh, el);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high; counts busy cycles seen
    task automatic wait_done(output int busy_cnt);
        int n;
        n = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_total++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    initial begin
        int bc;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        // Full-scale unsigned product, latency and busy length
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
        wait_done(bc);
        chk("busy_cycles", bc, 32);
        // Back-to-back from DONE with no IDLE cycle
        issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(bc);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);

        issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1);
        wait_done(bc); @(negedge clk);
        issue(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1);
        wait_done(bc); @(negedge clk);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
        wait_done(bc); @(negedge clk);
        issue(OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1);
        wait_done(bc); @(negedge clk);
        issue(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1);
        wait_done(bc); @(negedge clk);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1);
        wait_done(bc); @(negedge clk);
        issue(OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1);
        wait_done(bc); @(negedge clk);
        issue(OP_DIV,   32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1);
        wait_done(bc); @(negedge clk);

        // Start and MTHI during CALC are ignored; HI/LO hold until completion
        issue(OP_MULTU, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1);
        repeat (3) @(negedge clk);
        op = OP_DIVU; opr1 = 32'h5; opr2 = 32'h5; start = 1'b1;
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        opr1 = 32'hDEAD_BEEF; opr2 = 32'h1;
        chk("calc_hold_hi", hi, 32'hFFFF_FF9C);
        chk("calc_hold_lo", lo, 32'hFFFF_FFFF);
        chk("calc_busy", {31'd0, busy}, 32'd1);
        wait_done(bc); @(negedge clk);

        // Reset mid-division aborts it
        issue(OP_DIV, 32'd1000, 32'd7, 32'd0, 32'd0, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);

        // MTLO in IDLE, then both strobes together
        lo_we = 1'b1; wdata = 32'h0000_CAFE;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_CAFE);
        chk("mtlo_hi", hi, 32'd0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("both_hi", hi, 32'hA5A5_0001);
        chk("both_lo", lo, 32'hA5A5_0001);

        // Fresh operation after the abort
        issue(OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1);
        wait_done(bc);
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

endmodule
